// File: rtl/gb_lcd_pixel_tx_if.sv
// -----------------------------------------------------------------------------
// gb_lcd_pixel_tx_if
// Valid/ready pixel stream from the PPU into the GameBoy LCD pixel transmitter.
//
// Signals:
//   px_in        2  pixel shade
//   px_in_sof    1  marks px_in as pixel (0,0) of a frame
//   px_in_valid  1  px_in / px_in_sof are valid
//   px_in_ready  1  transmitter accepts the pixel on this edge
//
// Modports:
//   master  PPU side (drives pixels, observes ready)
//   slave   transmitter side (consumes pixels, drives ready)
// -----------------------------------------------------------------------------
interface gb_lcd_pixel_tx_if;
    logic [1:0] px_in;
    logic       px_in_sof;
    logic       px_in_valid;
    logic       px_in_ready;

    modport master (output px_in, output px_in_sof, output px_in_valid, input px_in_ready);
    modport slave  (input px_in, input px_in_sof, input px_in_valid, output px_in_ready);
endinterface

// File: rtl/gb_lcd_pixel_tx.sv
// -----------------------------------------------------------------------------
// gb_lcd_pixel_tx
// Transmit side of the GameBoy pixel conduit (LD / PX_VALID) feeding the VGA
// frame buffer. PPU shades are buffered in a small FIFO and emitted at most one
// per GameBoy_clk. Every frame is forced to exactly H_PIXELS x V_LINES writes
// (short frames are padded), so the sink's linear write address stays aligned.
//
// Ports:
//   GameBoy_clk      in   clock, all logic on its rising edge
//   GameBoy_reset_n  in   asynchronous active-low reset
//   lcd_en           in   LCD enable; low stops intake and finishes/pads the frame
//   test_mode        in   (only with GB_TX_TEST_PATTERN_EN) emit XOR test pattern
//   px               slave side of the PPU pixel stream
//   LD               out  pixel shade to the frame buffer
//   PX_VALID         out  LD valid, one write per assertion
//   frame_done       out  pulses together with the last PX_VALID of a frame
//   fifo_ovf         out  sticky: PPU offered a pixel that could not be taken
//
// Optional feature: define GB_TX_TEST_PATTERN_EN to add the test_mode input.
// -----------------------------------------------------------------------------
module gb_lcd_pixel_tx #(
    parameter int         H_PIXELS   = 160,
    parameter int         V_LINES    = 144,
    parameter int         FIFO_DEPTH = 16,
    parameter logic [1:0] PAD_PIXEL  = 2'b00
) (
    input  logic               GameBoy_clk,
    input  logic               GameBoy_reset_n,
    input  logic               lcd_en,
`ifdef GB_TX_TEST_PATTERN_EN
    input  logic               test_mode,
`endif
    gb_lcd_pixel_tx_if.slave   px,
    output logic [1:0]         LD,
    output logic               PX_VALID,
    output logic               frame_done,
    output logic               fifo_ovf
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int XW = $clog2(H_PIXELS);
    localparam int YW = $clog2(V_LINES);

    typedef enum logic [1:0] {IDLE, STREAM, PAD} state_t;

    state_t         state, state_next;
    logic [2:0]     mem [FIFO_DEPTH];   // {sof, shade}
    logic [AW:0]    wr_ptr, rd_ptr;
    logic [XW-1:0]  x;
    logic [YW-1:0]  y;

    logic           empty, full, head_sof, at_origin, frame_end;
    logic           ready, push, pop, flush, emit, test_sel;
    logic [1:0]     emit_px;
    logic [2:0]     head;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head      = mem[rd_ptr[AW-1:0]];
    assign head_sof  = head[2];
    assign at_origin = (x == '0) && (y == '0);
    assign frame_end = (x == XW'(H_PIXELS - 1)) && (y == YW'(V_LINES - 1));

`ifdef GB_TX_TEST_PATTERN_EN
    // test_mode only takes effect between frames; inside a frame the latched
    // choice is used so a frame is never part pattern, part PPU data.
    logic test_active;
    assign test_sel = at_origin ? test_mode : test_active;
`else
    assign test_sel = 1'b0;
`endif

    // Ready uses the pre-pop full flag, so a full FIFO refuses a push even if
    // it pops on the same edge.
    assign ready          = !full && (state != PAD) && lcd_en && !test_sel;
    assign px.px_in_ready = ready;
    assign push           = px.px_in_valid && ready;

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        flush      = 1'b0;
        emit       = 1'b0;
        emit_px    = head[1:0];
`ifdef GB_TX_TEST_PATTERN_EN
        if (test_sel) begin
            emit    = 1'b1;
            emit_px = {x[4] ^ y[4], x[3] ^ y[3]};
        end else
`endif
        begin
            case (state)
                IDLE: begin
                    // Discard stale data until a frame start reaches the head.
                    if (!lcd_en)
                        flush = 1'b1;
                    else if (!empty) begin
                        if (head_sof) state_next = STREAM;
                        else          pop        = 1'b1;
                    end
                end
                STREAM: begin
                    if (!lcd_en)
                        state_next = at_origin ? IDLE : PAD;
                    else if (!empty) begin
                        // A new frame start mid-frame: pad out the current
                        // frame first and keep the sof pixel for later.
                        if (head_sof && !at_origin)
                            state_next = PAD;
                        else begin
                            pop  = 1'b1;
                            emit = 1'b1;
                        end
                    end
                end
                PAD: begin
                    emit    = 1'b1;
                    emit_px = PAD_PIXEL;
                    if (frame_end)
                        state_next = (lcd_en && !empty && head_sof) ? STREAM : IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge GameBoy_clk or negedge GameBoy_reset_n) begin
        if (!GameBoy_reset_n) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            x          <= '0;
            y          <= '0;
            LD         <= 2'b00;
            PX_VALID   <= 1'b0;
            frame_done <= 1'b0;
            fifo_ovf   <= 1'b0;
        end else begin
            state      <= state_next;
            PX_VALID   <= emit;
            LD         <= emit ? emit_px : 2'b00;
            frame_done <= emit && frame_end;

            if (push)       wr_ptr <= wr_ptr + 1'b1;
            if (flush)      rd_ptr <= wr_ptr;
            else if (pop)   rd_ptr <= rd_ptr + 1'b1;

            if (emit) begin
                if (x == XW'(H_PIXELS - 1)) begin
                    x <= '0;
                    y <= (y == YW'(V_LINES - 1)) ? '0 : y + 1'b1;
                end else begin
                    x <= x + 1'b1;
                end
            end

            if (px.px_in_valid && !ready && lcd_en)
                fifo_ovf <= 1'b1;
        end
    end

`ifdef GB_TX_TEST_PATTERN_EN
    always_ff @(posedge GameBoy_clk or negedge GameBoy_reset_n) begin
        if (!GameBoy_reset_n) test_active <= 1'b0;
        else                  test_active <= test_sel;
    end
`endif

    // NOTE: the FIFO storage has no reset; the pointers alone define which
    // entries are valid, so clearing the array would only cost reset fan-out.
    always_ff @(posedge GameBoy_clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= {px.px_in_sof, px.px_in};
    end

endmodule
